// File: rtl/fractal_pkg.sv
// fractal_pkg: shared constants, types and palette helpers for fractal_colorizer.
package fractal_pkg;

  // Iteration count reported for points that never escaped.
  localparam logic [7:0] MAX_ITER = 8'd255;

  // Offset add, then palette read. Fixed by the datapath structure.
  localparam int PIPE_STAGES = 2;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    SYNC,
    PASS,
    DROP
  } colorizer_state_e;

  // One FIFO word: sideband on top, pixel colour below.
  typedef struct packed {
    logic tuser;
    logic tlast;
    rgb_t rgb;
  } fifo_entry_t;

  // Default palette, packed as {R, B, G}: R = idx, G = idx * 2, B = ~idx.
  function automatic rgb_t gradient(input logic [7:0] idx);
    return {idx, ~idx, {idx[6:0], 1'b0}};
  endfunction

  // Whole default palette flattened, entry i at bits [i*24 +: 24].
  function automatic logic [256*24-1:0] gradient_table();
    logic [256*24-1:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[i*24 +: 24] = gradient(8'(i));
    return t;
  endfunction

endpackage

// File: rtl/fractal_colorizer_fifo.sv
// colorizer_fifo: synchronous show-ahead FIFO. The head word is visible on
// rdata whenever the FIFO is not empty, and reads as zero when it is empty.
// A pop in the same cycle frees a slot, so full already accounts for it.
module colorizer_fifo
  import fractal_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign full    = (level == LVL_W'(DEPTH)) && !do_pop;
  assign do_push = push && !full;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; only pointers and level do, which
  // keeps it mappable to RAM and is enough because empty masks stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state is always assigned with <= so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fractal_colorizer.sv
// fractal_colorizer: maps the generator's iteration-count stream through a
// rotated 256-entry palette and emits whole frames on AXI4-Stream video.
// Build option FRACTAL_PALETTE_RAM_EN: palette becomes a writable 256x24 RAM
// (pal_* ports) seeded with the gradient; otherwise the gradient is fixed.
module fractal_colorizer
  import fractal_pkg::*;
#(
  parameter int FIFO_DEPTH = 16  // power of two, at least 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  data_in,
  input  logic        frame_start_in,
  input  logic        line_end_in,
  input  logic        data_enable_in,
  input  logic [7:0]  color_offset,
  input  logic        overflow_clr,
`ifdef FRACTAL_PALETTE_RAM_EN
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata,
`endif
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow
);

  // ---------------- stage 1: offset add ----------------
  logic [7:0] offset_q;
  logic [7:0] offset_sel;
  logic       s1_valid;
  logic [7:0] s1_idx;
  logic       s1_interior;
  logic       s1_fs;
  logic       s1_le;

  // The frame-start pixel already uses the offset it latches.
  assign offset_sel = (data_enable_in && frame_start_in) ? color_offset : offset_q;

  // Latch the per-frame offset and register the rotated palette index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      offset_q    <= '0;
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_interior <= 1'b0;
      s1_fs       <= 1'b0;
      s1_le       <= 1'b0;
    end else begin
      if (data_enable_in && frame_start_in) offset_q <= color_offset;
      s1_valid    <= data_enable_in;
      s1_idx      <= data_in + offset_sel;
      s1_interior <= (data_in == MAX_ITER);
      s1_fs       <= frame_start_in;
      s1_le       <= line_end_in;
    end
  end

  // ---------------- palette ----------------
  rgb_t pal_rgb;

`ifdef FRACTAL_PALETTE_RAM_EN
  // Flattened 256x24 store; power-up contents are the gradient and reset
  // leaves it alone so a loaded palette survives a stream resync.
  logic [256*24-1:0] pal_q = gradient_table();
  logic [12:0]       pal_rd_base;
  logic [12:0]       pal_wr_base;

  assign pal_rd_base = 13'({s1_idx, 4'b0})   + 13'({s1_idx, 3'b0});
  assign pal_wr_base = 13'({pal_addr, 4'b0}) + 13'({pal_addr, 3'b0});
  assign pal_rgb     = pal_q[pal_rd_base +: 24];

  // Palette write; a same-cycle read of that address still sees old data.
  always_ff @(posedge clk) begin
    if (pal_we) pal_q[pal_wr_base +: 24] <= pal_wdata;
  end
`else
  assign pal_rgb = gradient(s1_idx);
`endif

  // ---------------- stage 2: palette read ----------------
  logic s2_valid;
  rgb_t s2_rgb;
  logic s2_fs;
  logic s2_le;

  // Register the colour (black for interior points) and delay the sideband.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_rgb   <= '0;
      s2_fs    <= 1'b0;
      s2_le    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_rgb   <= s1_interior ? '0 : pal_rgb;
      s2_fs    <= s1_fs;
      s2_le    <= s1_le;
    end
  end

  // ---------------- write control ----------------
  colorizer_state_e state;
  colorizer_state_e state_nx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push;
  logic             drop;
  fifo_entry_t      wr_entry;
  fifo_entry_t      rd_entry;

  assign fifo_pop = m_axis_tvalid && m_axis_tready;
  assign wr_entry = '{tuser: s2_fs, tlast: s2_le, rgb: s2_rgb};

  // One write/discard decision per stage-2 pixel; SYNC discards are silent.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    state_nx = state;
    if (s2_valid) begin
      unique case (state)
        SYNC: begin
          if (s2_fs && !fifo_full) begin
            push     = 1'b1;
            state_nx = PASS;
          end
        end
        PASS: begin
          if (fifo_full) begin
            drop     = 1'b1;
            state_nx = DROP;
          end else begin
            push = 1'b1;
          end
        end
        DROP: begin
          if (s2_fs && !fifo_full) begin
            push     = 1'b1;
            state_nx = PASS;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_nx = SYNC;
      endcase
    end
  end

  // FSM state and sticky overflow flag; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= SYNC;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  colorizer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (wr_entry),
    .pop    (fifo_pop),
    .rdata  (rd_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tuser  = rd_entry.tuser;
  assign m_axis_tlast  = rd_entry.tlast;
  assign m_axis_tdata  = rd_entry.rgb;

endmodule
